// File: rtl/popcount_sequencer.sv
// Drives a bit_counter with one accepted byte at a time, collects its ones count,
// and presents the per-word count plus a running sum, guarded by a watchdog.
module popcount_sequencer #(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 4,
    parameter int SUM_W   = 12,
    parameter int TIMEOUT = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] bc_A,
    output logic              bc_start,
    input  logic [CNT_W-1:0]  bc_result,
    input  logic              bc_done,
    output logic [CNT_W-1:0]  out_count,
    output logic [SUM_W-1:0]  out_sum,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              clear_sum,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CLR  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    state_t            state_r;
    logic [7:0]        wdog_r;
    logic              in_ready_r;
    logic              bc_start_r;
    logic              out_valid_r;
    logic              timeout_err_r;
    logic [DATA_W-1:0] bc_a_r;
    logic [CNT_W-1:0]  out_count_r;
    logic [SUM_W-1:0]  out_sum_r;
    logic [SUM_W-1:0]  sum_base_s;
    logic [SUM_W-1:0]  sum_add_s;
    logic              wdog_exp_s;

    // Clear-before-add: a coincident clear_sum leaves only the new count in the sum
    always_comb begin
        if (clear_sum) begin
            sum_base_s = '0;
        end else begin
            sum_base_s = out_sum_r;
        end
        sum_add_s  = sum_base_s + SUM_W'(bc_result);
        wdog_exp_s = (wdog_r == 8'(TIMEOUT - 1));
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            wdog_r        <= 8'd0;
            in_ready_r    <= 1'b0;
            bc_start_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            timeout_err_r <= 1'b0;
            bc_a_r        <= '0;
            out_count_r   <= '0;
            out_sum_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clear_sum) begin
                        out_sum_r <= '0;
                    end
                    if (in_valid && in_ready_r) begin
                        bc_a_r     <= in_data;
                        bc_start_r <= 1'b1;
                        in_ready_r <= 1'b0;
                        wdog_r     <= 8'd0;
                        state_r    <= ST_RUN;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // wdog_r == 0 marks the first RUN cycle, where a high done is stale
                    if (bc_done && (wdog_r != 8'd0)) begin
                        out_count_r <= bc_result;
                        out_sum_r   <= sum_add_s;
                        bc_start_r  <= 1'b0;
                        wdog_r      <= 8'd0;
                        state_r     <= ST_CLR;
                    end else if (wdog_exp_s) begin
                        timeout_err_r <= 1'b1;
                        bc_start_r    <= 1'b0;
                        out_count_r   <= '0;
                        in_ready_r    <= 1'b1;
                        wdog_r        <= 8'd0;
                        state_r       <= ST_IDLE;
                        if (clear_sum) begin
                            out_sum_r <= '0;
                        end
                    end else begin
                        wdog_r <= wdog_r + 8'd1;
                        if (clear_sum) begin
                            out_sum_r <= '0;
                        end
                    end
                end
                ST_CLR: begin
                    if (clear_sum) begin
                        out_sum_r <= '0;
                    end
                    if (!bc_done) begin
                        out_valid_r <= 1'b1;
                        wdog_r      <= 8'd0;
                        state_r     <= ST_OUT;
                    end else if (wdog_exp_s) begin
                        timeout_err_r <= 1'b1;
                        out_count_r   <= '0;
                        in_ready_r    <= 1'b1;
                        wdog_r        <= 8'd0;
                        state_r       <= ST_IDLE;
                    end else begin
                        wdog_r <= wdog_r + 8'd1;
                    end
                end
                ST_OUT: begin
                    // Held outputs stay frozen; a clear still asserted at the handshake applies
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                        if (clear_sum) begin
                            out_sum_r <= '0;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    bc_start_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b0;
                    wdog_r      <= 8'd0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign bc_A        = bc_a_r;
    assign bc_start    = bc_start_r;
    assign out_count   = out_count_r;
    assign out_sum     = out_sum_r;
    assign out_valid   = out_valid_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_popcount_sequencer.sv
// Bench for popcount_sequencer: behavioural bit_counter, directed corner cases,
// and randomized traffic checked against a queue-based reference.
module tb_popcount_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready, in_ready4;
    logic [7:0]  bc_A, bc_A4;
    logic        bc_start, bc_start4;
    logic [3:0]  bc_result;
    logic        bc_done_m, force_done, bc_done;
    logic [3:0]  out_count, out_count4;
    logic [11:0] out_sum;
    logic [3:0]  out_sum4;
    logic        out_valid, out_valid4;
    logic        out_ready, clear_sum;
    logic        timeout_err, timeout_err4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign bc_done = bc_done_m | force_done;

    popcount_sequencer u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .bc_A(bc_A), .bc_start(bc_start), .bc_result(bc_result), .bc_done(bc_done),
        .out_count(out_count), .out_sum(out_sum), .out_valid(out_valid), .out_ready(out_ready),
        .clear_sum(clear_sum), .timeout_err(timeout_err)
    );

    // Narrow-sum instance fed the same stimulus and counter responses
    popcount_sequencer #(.SUM_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
        .bc_A(bc_A4), .bc_start(bc_start4), .bc_result(bc_result), .bc_done(bc_done),
        .out_count(out_count4), .out_sum(out_sum4), .out_valid(out_valid4), .out_ready(out_ready),
        .clear_sum(clear_sum), .timeout_err(timeout_err4)
    );

    function automatic int ones(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) if (v[i]) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural bit_counter: latches A on start, answers after bc_lat cycles
    int         bc_lat = 2;
    bit         bc_stuck = 1'b0;
    int         bc_left;
    bit         bc_busy;
    logic [7:0] bc_cap;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bc_busy   <= 1'b0;
            bc_done_m <= 1'b0;
            bc_left   <= 0;
            bc_result <= 4'd0;
        end else if (bc_busy) begin
            if (bc_left == 0) begin
                bc_busy   <= 1'b0;
                bc_done_m <= 1'b1;
                bc_result <= 4'(ones(bc_cap));
            end else begin
                bc_left <= bc_left - 1;
            end
        end else if (bc_done_m) begin
            if (!bc_start) bc_done_m <= 1'b0;
        end else if (bc_start && !bc_stuck) begin
            bc_busy <= 1'b1;
            bc_left <= bc_lat;
            bc_cap  <= bc_A;
        end
    end

    // bc_A must not move while bc_start is held
    logic [7:0] a_hold;
    bit         start_prev = 1'b0;
    always @(negedge clk) begin
        if (bc_start === 1'b1 && start_prev) chk("bc_A_stable", 32'(bc_A), 32'(a_hold));
        if (bc_start === 1'b1 && !start_prev) a_hold <= bc_A;
        start_prev <= (bc_start === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    task automatic push_word(input logic [7:0] d);
        int n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("push_wait", 32'(n < 200), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] d, input logic [3:0] ec, input logic [11:0] es, input string nm);
        int n = 0;
        push_word(d);
        out_ready = 1'b1;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_wait"}, 32'(n < 200), 32'd1);
        chk({nm, "_count"}, 32'(out_count), 32'(ec));
        chk({nm, "_sum"}, 32'(out_sum), 32'(es));
        chk({nm, "_sum4"}, 32'(out_sum4), 32'(es[3:0]));
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [3:0]  c;
        logic [11:0] s;
    } vec_t;
    vec_t tbl[4];

    logic [7:0] q[$];
    int  msum;
    bit  acc, stalled, seen_valid;
    logic [3:0]  hold_c;
    logic [11:0] hold_s;

    task automatic rand_cycle(input bit allow);
        logic [7:0] w;
        if (acc) begin in_valid = 1'b0; acc = 1'b0; end
        if (!in_valid && allow && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        out_ready = 1'($urandom_range(0, 1));
        clear_sum = (in_ready === 1'b1) && ($urandom_range(0, 7) == 0);
        bc_lat    = $urandom_range(0, 4);
        @(negedge clk);
        if (stalled) begin
            chk("rnd_hold_valid", 32'(out_valid), 32'd1);
            chk("rnd_hold_count", 32'(out_count), 32'(hold_c));
            chk("rnd_hold_sum", 32'(out_sum), 32'(hold_s));
        end
        stalled = 1'b0;
        if (out_valid === 1'b1) begin
            if (out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_out", 32'd1, 32'd0);
                end else begin
                    w    = q.pop_front();
                    msum = (msum + ones(w)) % 4096;
                    chk("rnd_count", 32'(out_count), 32'(ones(w)));
                    chk("rnd_sum", 32'(out_sum), 32'(msum));
                    chk("rnd_sum4", 32'(out_sum4), 32'(msum % 16));
                end
            end else begin
                stalled = 1'b1;
                hold_c  = out_count;
                hold_s  = out_sum;
            end
        end
        if (clear_sum) msum = 0;
        if (in_valid && in_ready === 1'b1) begin
            q.push_back(in_data);
            acc = 1'b1;
        end
        @(posedge clk); #1;
        clear_sum = 1'b0;
    endtask

    initial begin
        int n;
        tbl[0] = '{8'hAA, 4'd4, 12'd4};
        tbl[1] = '{8'h55, 4'd4, 12'd8};
        tbl[2] = '{8'hFF, 4'd8, 12'd16};
        tbl[3] = '{8'h00, 4'd0, 12'd16};

        reset = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        clear_sum = 1'b0; force_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_bc_start", 32'(bc_start), 32'd0);
        chk("rst_bc_A", 32'(bc_A), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst4_outs", 32'({in_ready4, bc_start4, bc_A4, out_count4, out_sum4, out_valid4, timeout_err4}), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Basic words
        for (int i = 0; i < 4; i++) xfer(tbl[i].d, tbl[i].c, tbl[i].s, $sformatf("tbl%0d", i));

        // clear_sum in first RUN cycle, before the capture
        bc_lat = 3;
        push_word(8'h0F);
        clear_sum = 1'b1;
        @(posedge clk); #1;
        clear_sum = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        chk("clr_run_count", 32'(out_count), 32'd4);
        chk("clr_run_sum", 32'(out_sum), 32'd4);
        @(posedge clk); #1; out_ready = 1'b0;

        // clear_sum coincident with the capture edge
        bc_lat = 0;
        push_word(8'h07);
        n = 0;
        while (bc_done !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        chk("clr_cap_wait", 32'(n < 50), 32'd1);
        clear_sum = 1'b1;
        @(posedge clk); #1;
        clear_sum = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        chk("clr_cap_count", 32'(out_count), 32'd3);
        chk("clr_cap_sum", 32'(out_sum), 32'd3);
        @(posedge clk); #1; out_ready = 1'b0;

        // done already high in the first RUN cycle is stale
        bc_lat = 2;
        push_word(8'h01);
        force_done = 1'b1;
        @(posedge clk); #1;
        force_done = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        chk("stale_count", 32'(out_count), 32'd1);
        chk("stale_sum", 32'(out_sum), 32'd4);
        @(posedge clk); #1; out_ready = 1'b0;

        // Output stall with a word offered meanwhile
        push_word(8'hAA);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        in_data = 8'h0F; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_count", 32'(out_count), 32'd4);
            chk("stall_sum", 32'(out_sum), 32'd8);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        xfer(8'h0F, 4'd4, 12'd12, "after_stall");

        // Hung counter trips the watchdog
        bc_stuck = 1'b1;
        push_word(8'h33);
        n = 0; seen_valid = 1'b0;
        while (timeout_err !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        chk("to_cycles", 32'(n), 32'd31);
        chk("to_bc_start", 32'(bc_start), 32'd0);
        chk("to_in_ready", 32'(in_ready), 32'd1);
        chk("to_out_count", 32'(out_count), 32'd0);
        chk("to_out_sum", 32'(out_sum), 32'd12);
        chk("to_no_valid", 32'(seen_valid), 32'd0);
        chk("to_err4", 32'(timeout_err4), 32'd1);
        bc_stuck = 1'b0;
        xfer(8'h03, 4'd2, 12'd14, "post_to");
        chk("to_sticky", 32'(timeout_err), 32'd1);

        // Reset while RUN
        bc_lat = 6;
        push_word(8'hF0);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_bc_start", 32'(bc_start), 32'd0);
        chk("mid_rst_outs", 32'({in_ready, bc_A, out_count, out_sum, out_valid, timeout_err}), 32'd0);
        chk("mid_rst_sum4", 32'(out_sum4), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        bc_lat = 2;
        xfer(8'h0F, 4'd4, 12'd4, "post_rst");

        // Narrow sum wraps: 8 then 0 on the 4-bit instance
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        xfer(8'hFF, 4'd8, 12'd8, "wrap_a");
        xfer(8'hFF, 4'd8, 12'd16, "wrap_b");

        // Randomized traffic against the queue model
        msum = 16; acc = 1'b0; stalled = 1'b0;
        for (int c = 0; c < 1500; c++) rand_cycle(1'b1);
        for (int c = 0; c < 100; c++) rand_cycle(1'b0);
        chk("rnd_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
